// File: rtl/lcd_spi_pkg.sv
// Shared LCD SPI definitions: command opcodes, decode FSM states, coordinate type.
// Used by both the transmit-side drawers and the display-side receiver.
package lcd_spi_pkg;

  localparam logic [7:0] CMD_SET_COLUMN = 8'h2A;
  localparam logic [7:0] CMD_SET_PAGE   = 8'h2B;
  localparam logic [7:0] CMD_WRITE_RAM  = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COL  = 2'd1,
    ST_PAGE = 2'd2,
    ST_RAM  = 2'd3
  } rx_state_t;

  typedef logic [8:0] coord_t;

endpackage

// File: rtl/spi_rx_byte.sv
// SPI mode-0 byte deserialiser: byte_vld is a registered strobe SYNC_STAGES+1 clk after the raw SCK edge.
// No backpressure; CS high discards any partial byte.
module spi_rx_byte #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs,
  input  logic       dc,
  input  logic       mosi,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       byte_dc
);

  logic [SYNC_STAGES-1:0] sclk_q, cs_q, dc_q, mosi_q;
  logic       sclk_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       sclk_s, cs_s, dc_s, mosi_s, sclk_rise;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign dc_s      = dc_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q   <= '0;
      cs_q     <= '1;
      dc_q     <= '0;
      mosi_q   <= '0;
      sclk_d   <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
      byte_vld <= 1'b0;
      byte_dat <= '0;
      byte_dc  <= 1'b0;
    end else begin
      // All four lines share the same depth so their relative order is preserved.
      sclk_q   <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q     <= {cs_q[SYNC_STAGES-2:0], cs};
      dc_q     <= {dc_q[SYNC_STAGES-2:0], dc};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d   <= sclk_s;
      byte_vld <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_dat <= {shift, mosi_s};
          byte_dc  <= dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/spi_lcd_rx.sv
// LCD SPI receiver: decodes column/page/RAM commands into pixel-write events, strobes 1 clk after the byte strobe.
// No backpressure; every received byte is consumed immediately.
module spi_lcd_rx
  import lcd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int H_MAX       = 240,
  parameter int V_MAX       = 320
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sclk,
  input  logic        i_cs,
  input  logic        i_dc,
  input  logic        i_mosi,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_px_valid,
  output logic [8:0]  o_x,
  output logic [8:0]  o_y,
  output logic [15:0] o_color,
  output logic        o_err
);

  localparam coord_t X_LAST = coord_t'(H_MAX - 1);
  localparam coord_t Y_LAST = coord_t'(V_MAX - 1);

  logic       byte_vld, byte_dc;
  logic [7:0] byte_dat;

  spi_rx_byte #(.SYNC_STAGES(SYNC_STAGES)) u_rx_byte (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .sclk     (i_sclk),
    .cs       (i_cs),
    .dc       (i_dc),
    .mosi     (i_mosi),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat),
    .byte_dc  (byte_dc)
  );

  rx_state_t   state, state_nxt;
  logic [1:0]  pcnt;
  logic [7:0]  p0, p1, p2, hi;
  logic        phase;
  coord_t      xs, xe, ys, ye, cx, cy;
  logic [15:0] pstart, pend;
  logic        cmd_hit, data_hit, last_param;
  logic        win_ok, commit_col, commit_page, px_hit, err_hit;

  assign cmd_hit    = byte_vld & ~byte_dc;
  assign data_hit   = byte_vld & byte_dc;
  assign last_param = (pcnt == 2'd3);
  assign pstart     = {p0, p1};
  assign pend       = {p2, byte_dat};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cmd_hit) begin
      case (byte_dat)
        CMD_SET_COLUMN: state_nxt = ST_COL;
        CMD_SET_PAGE:   state_nxt = ST_PAGE;
        CMD_WRITE_RAM:  state_nxt = ST_RAM;
        default:        state_nxt = ST_IDLE;
      endcase
    end else if (data_hit && (state == ST_COL || state == ST_PAGE) && last_param) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    win_ok      = 1'b0;
    commit_col  = 1'b0;
    commit_page = 1'b0;
    px_hit      = 1'b0;
    err_hit     = 1'b0;
    case (state)
      ST_COL:  win_ok = (pstart <= pend) && (pend < 16'(H_MAX));
      ST_PAGE: win_ok = (pstart <= pend) && (pend < 16'(V_MAX));
      default: win_ok = 1'b0;
    endcase
    if (data_hit) begin
      case (state)
        ST_IDLE: err_hit = 1'b1;
        ST_COL: begin
          commit_col = last_param & win_ok;
          err_hit    = last_param & ~win_ok;
        end
        ST_PAGE: begin
          commit_page = last_param & win_ok;
          err_hit     = last_param & ~win_ok;
        end
        ST_RAM:  px_hit = phase;
        default: err_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cmd_valid <= 1'b0;
      o_px_valid  <= 1'b0;
      o_err       <= 1'b0;
      o_cmd       <= '0;
      o_x         <= '0;
      o_y         <= '0;
      o_color     <= '0;
      xs          <= '0;
      xe          <= X_LAST;
      ys          <= '0;
      ye          <= Y_LAST;
      cx          <= '0;
      cy          <= '0;
      pcnt        <= '0;
      p0          <= '0;
      p1          <= '0;
      p2          <= '0;
      hi          <= '0;
      phase       <= 1'b0;
    end else begin
      o_cmd_valid <= cmd_hit;
      o_px_valid  <= px_hit;
      o_err       <= err_hit;
      if (commit_col) begin
        xs <= pstart[8:0];
        xe <= pend[8:0];
      end
      if (commit_page) begin
        ys <= pstart[8:0];
        ye <= pend[8:0];
      end
      if (cmd_hit) begin
        o_cmd <= byte_dat;
        pcnt  <= '0;
        phase <= 1'b0;
        if (byte_dat == CMD_WRITE_RAM) begin
          cx <= xs;
          cy <= ys;
        end
      end else if (data_hit && (state == ST_COL || state == ST_PAGE)) begin
        pcnt <= pcnt + 2'd1;
        case (pcnt)
          2'd0:    p0 <= byte_dat;
          2'd1:    p1 <= byte_dat;
          2'd2:    p2 <= byte_dat;
          default: p2 <= p2;
        endcase
      end else if (data_hit && state == ST_RAM) begin
        phase <= ~phase;
        if (!phase) begin
          hi <= byte_dat;
        end else begin
          o_x     <= cx;
          o_y     <= cy;
          o_color <= {hi, byte_dat};
          // Raster order inside the window, wrapping back to the window origin.
          if (cx == xe) begin
            cx <= xs;
            cy <= (cy == ye) ? ys : cy + 9'd1;
          end else begin
            cx <= cx + 9'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Bench for spi_lcd_rx: directed scenarios then random command/pixel streams, scored against a window/index model.
module tb_spi_lcd_rx;

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_sclk = 1'b0, i_cs = 1'b1, i_dc = 1'b0, i_mosi = 1'b0;
  logic        o_cmd_valid, o_px_valid, o_err;
  logic [7:0]  o_cmd;
  logic [8:0]  o_x, o_y;
  logic [15:0] o_color;

  always #5 i_clk = ~i_clk;

  spi_lcd_rx #(.SYNC_STAGES(2), .H_MAX(240), .V_MAX(320)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_cs(i_cs), .i_dc(i_dc), .i_mosi(i_mosi),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_px_valid(o_px_valid),
    .o_x(o_x), .o_y(o_y), .o_color(o_color), .o_err(o_err)
  );

  int n_vec = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Expected events: kind 1 = command, 2 = pixel, 3 = error.
  typedef struct { int kind; int cmd; int x; int y; int col; } ev_t;
  ev_t exp_q[$];

  int mode, pc, xs, xe, ys, ye, idx, hi;
  int prm[4];
  bit have_hi;
  time t_last;

  function automatic void push_ev(int kind, int cmd, int x, int y, int col);
    ev_t e;
    e.kind = kind; e.cmd = cmd; e.x = x; e.y = y; e.col = col;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    mode = 0; pc = 0; xs = 0; xe = 239; ys = 0; ye = 319; idx = 0; have_hi = 0; hi = 0;
  endfunction

  // Pixels are numbered from the window origin; position follows from the window size.
  function automatic void model_byte(bit dc, int b);
    int s, e, lim, w, h;
    if (!dc) begin
      push_ev(1, b, 0, 0, 0);
      pc = 0;
      if (b == 'h2A) mode = 1;
      else if (b == 'h2B) mode = 2;
      else if (b == 'h2C) begin mode = 3; idx = 0; have_hi = 0; end
      else mode = 0;
    end else if (mode == 1 || mode == 2) begin
      prm[pc] = b;
      pc++;
      if (pc == 4) begin
        s = prm[0] * 256 + prm[1];
        e = prm[2] * 256 + prm[3];
        lim = (mode == 1) ? 240 : 320;
        if (s <= e && e < lim) begin
          if (mode == 1) begin xs = s; xe = e; end
          else begin ys = s; ye = e; end
        end else push_ev(3, 0, 0, 0, 0);
        mode = 0;
      end
    end else if (mode == 3) begin
      if (!have_hi) begin
        hi = b; have_hi = 1;
      end else begin
        w = xe - xs + 1;
        h = ye - ys + 1;
        push_ev(2, 0, xs + idx % w, ys + (idx / w) % h, hi * 256 + b);
        idx++;
        have_hi = 0;
      end
    end else begin
      push_ev(3, 0, 0, 0, 0);
    end
  endfunction

  task automatic send_bits(input bit dc, input logic [7:0] b, input int n);
    @(posedge i_clk);
    #5;
    i_cs = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      i_dc = dc;
      i_mosi = b[i];
      #40 i_sclk = 1'b1;
      if (i == 0) t_last = $time;
      #40 i_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    model_byte(dc, int'(b));
    send_bits(dc, b, 8);
  endtask

  task automatic send_win(input logic [7:0] c, input int s, input int e);
    logic [15:0] sv, ev;
    sv = 16'(s); ev = 16'(e);
    send_byte(0, c);
    send_byte(1, sv[15:8]); send_byte(1, sv[7:0]);
    send_byte(1, ev[15:8]); send_byte(1, ev[7:0]);
  endtask

  task automatic send_px(input logic [15:0] c);
    send_byte(1, c[15:8]);
    send_byte(1, c[7:0]);
  endtask

  task automatic check_reset_outputs();
    @(negedge i_clk);
    check("rst_cmd_valid", o_cmd_valid, 0);
    check("rst_px_valid", o_px_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_cmd", o_cmd, 0);
    check("rst_x", o_x, 0);
    check("rst_y", o_y, 0);
    check("rst_color", o_color, 0);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  initial begin
    ev_t e;
    int kind;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && (o_cmd_valid || o_px_valid || o_err)) begin
        kind = o_cmd_valid ? 1 : (o_px_valid ? 2 : 3);
        check("one_strobe", int'(o_cmd_valid) + int'(o_px_valid) + int'(o_err), 1);
        check("latency", ($time - t_last) / 10, 4);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_event got=kind%0d expected=none", kind);
        end else begin
          e = exp_q.pop_front();
          check("kind", kind, e.kind);
          if (kind == e.kind && kind == 1) check("cmd", o_cmd, e.cmd);
          if (kind == e.kind && kind == 2)
            check("px", {o_x, o_y, o_color}, {9'(e.x), 9'(e.y), 16'(e.col)});
        end
      end
    end
  end

  initial begin
    int r, n, s, e, c;
    model_reset();
    t_last = 0;
    repeat (5) @(posedge i_clk);
    check_reset_outputs();
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);

    // Window 10..12 x 5..5, three primaries.
    send_win(8'h2A, 10, 12);
    send_win(8'h2B, 5, 5);
    send_byte(0, 8'h2C);
    send_px(16'hF800); send_px(16'h07E0); send_px(16'h001F);

    // 2x2 window, fifth pixel wraps to the origin.
    send_win(8'h2A, 10, 11);
    send_win(8'h2B, 5, 6);
    send_byte(0, 8'h2C);
    for (int i = 0; i < 5; i++) send_px(16'(16'h1000 + i));

    // start > end, then end == H_MAX, then an abandoned update.
    send_win(8'h2A, 20, 10);
    send_byte(0, 8'h2C);
    send_px(16'hABCD);
    send_win(8'h2A, 0, 240);
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h01);
    send_byte(0, 8'h2C);
    send_px(16'h1234);

    // Partial byte discarded by CS high.
    send_bits(1, 8'hA5, 5);
    #40 i_cs = 1'b1;
    repeat (10) @(posedge i_clk);
    i_cs = 1'b0;
    repeat (10) @(posedge i_clk);
    send_px(16'hFFFF);

    // Reset between the two bytes of a pixel.
    send_byte(1, 8'hAB);
    repeat (8) @(posedge i_clk);
    i_rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    check_reset_outputs();
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    send_byte(1, 8'h55);
    send_byte(0, 8'h2C);
    send_px(16'h0F0F);

    // Random traffic.
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        n = ($urandom_range(0, 4) == 0) ? 2 : 4;
        s = (r <= 2) ? $urandom_range(0, 250) : $urandom_range(0, 330);
        e = (r <= 2) ? $urandom_range(0, 250) : $urandom_range(0, 330);
        if ($urandom_range(0, 1) == 1 && s > e) begin c = s; s = e; e = c; end
        send_byte(0, (r <= 2) ? 8'h2A : 8'h2B);
        send_byte(1, 8'(s >> 8)); send_byte(1, 8'(s));
        if (n == 4) begin send_byte(1, 8'(e >> 8)); send_byte(1, 8'(e)); end
      end else if (r <= 8) begin
        send_byte(0, 8'h2C);
        n = $urandom_range(1, 9);
        for (int k = 0; k < n; k++) send_byte(1, 8'($urandom_range(0, 255)));
      end else begin
        c = $urandom_range(0, 255);
        if (c >= 'h2A && c <= 'h2C) c = 0;
        send_byte(0, 8'(c));
        if ($urandom_range(0, 1) == 1) send_byte(1, 8'($urandom_range(0, 255)));
      end
    end

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge i_clk);
    repeat (5) @(posedge i_clk);
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
